sumfp_quant_pipe: RTL and testbench

//  Pipelined successor of the combinational fixed-point adder: signed A + B with different Q formats.

---
 rtl/sumfp_pkg.sv | 29 ++
 rtl/sumfp_quant_pipe_if.sv | 26 ++
 rtl/fxp_quant.sv | 37 +++
 rtl/sumfp_quant_pipe.sv | 86 ++++++++
 tb/tb_sumfp_quant_pipe.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sumfp_pkg.sv
// sumfp_pkg: formats, quantisation mode codes and full-resolution width helpers
package sumfp_pkg;
    localparam int NB_IN_A  = 16;
    localparam int NBF_IN_A = 14;
    localparam int NB_IN_B  = 12;
    localparam int NBF_IN_B = 11;
    localparam int NB_OUT   = 11;
    localparam int NBF_OUT  = 10;
    localparam int NB_CNT   = 16;

    typedef enum logic [1:0] {
        QM_TRUNC_WRAP = 2'd0,
        QM_TRUNC_SAT  = 2'd1,
        QM_RND_HU     = 2'd2,
        QM_RND_HE     = 2'd3
    } qmode_e;

    function automatic int nbi_fr(input int nb_a, input int nbf_a, input int nb_b, input int nbf_b);
        return (((nb_a - nbf_a) > (nb_b - nbf_b)) ? (nb_a - nbf_a) : (nb_b - nbf_b)) + 1;
    endfunction

    function automatic int nbf_fr(input int nbf_a, input int nbf_b);
        return (nbf_a > nbf_b) ? nbf_a : nbf_b;
    endfunction

    localparam int NBI_FR = nbi_fr(NB_IN_A, NBF_IN_A, NB_IN_B, NBF_IN_B);
    localparam int NBF_FR = nbf_fr(NBF_IN_A, NBF_IN_B);
    localparam int NB_FR  = NBI_FR + NBF_FR;
endpackage

// File: rtl/sumfp_quant_pipe_if.sv
// sumfp_quant_pipe_if: operand/result handshakes plus overflow status and clear
interface sumfp_quant_pipe_if;
    import sumfp_pkg::*;
    logic                i_valid;
    logic                o_ready;
    logic [NB_IN_A-1:0]  i_A;
    logic [NB_IN_B-1:0]  i_B;
    logic [1:0]          i_mode;
    logic                o_valid;
    logic                i_ready;
    logic [NB_OUT-1:0]   o_data;
    logic                o_ovf;
    logic                o_ovf_stky;
    logic                i_clr;
    logic [NB_CNT-1:0]   o_sat_cnt;

    modport master (
        output i_valid, i_A, i_B, i_mode, i_ready, i_clr,
        input  o_ready, o_valid, o_data, o_ovf, o_ovf_stky, o_sat_cnt
    );

    modport slave (
        input  i_valid, i_A, i_B, i_mode, i_ready, i_clr,
        output o_ready, o_valid, o_data, o_ovf, o_ovf_stky, o_sat_cnt
    );
endinterface

// File: rtl/fxp_quant.sv
// fxp_quant: combinational full-resolution to output-format quantiser (wrap/saturate, truncate/round)
module fxp_quant
    import sumfp_pkg::*;
#(
    parameter int NB_FR   = 17,
    parameter int NBF_FR  = 14,
    parameter int NB_OUT  = 11,
    parameter int NBF_OUT = 10
) (
    input  logic [NB_FR-1:0]  fr_i,
    input  qmode_e            mode_i,
    output logic [NB_OUT-1:0] data_o,
    output logic              ovf_o
);
    localparam int DROP = NBF_FR - NBF_OUT;
    localparam int NB_X = NB_FR + 1;
    localparam int NB_K = NB_X - DROP;
    localparam logic [NB_X-1:0] HALF = NB_X'((2 ** DROP) / 2);

    logic [NB_X-1:0]        x;
    logic [NB_X-1:0]        rnd;
    logic [NB_K-1:0]        k;
    logic [NB_K-NB_OUT:0]   msb_grp;

    // one guard bit keeps the rounding carry; half-even adds half-1 plus the kept LSB
    always_comb begin
        x       = {fr_i[NB_FR-1], fr_i};
        rnd     = (mode_i == QM_RND_HU) ? HALF :
                  (mode_i == QM_RND_HE && DROP > 0) ? HALF - NB_X'(1) + NB_X'(x[DROP]) : '0;
        k       = NB_K'((x + rnd) >> DROP);
        msb_grp = k[NB_K-1:NB_OUT-1];
        ovf_o   = ~(&msb_grp) & (|msb_grp);
        data_o  = (ovf_o && mode_i != QM_TRUNC_WRAP) ?
                  (msb_grp[NB_K-NB_OUT] ? {1'b1, {(NB_OUT-1){1'b0}}} : {1'b0, {(NB_OUT-1){1'b1}}}) :
                  k[NB_OUT-1:0];
    end
endmodule

// File: rtl/sumfp_quant_pipe.sv
// sumfp_quant_pipe: 2-stage A+B fixed-point adder with runtime re-quantisation and valid/ready.
// SUMFP_SAT_CNT_EN enables the saturation event counter on o_sat_cnt.
module sumfp_quant_pipe
    import sumfp_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    sumfp_quant_pipe_if.slave bus
);
    localparam int SH_A = NBF_FR - NBF_IN_A;
    localparam int SH_B = NBF_FR - NBF_IN_B;

    logic                    adv, cons;
    logic signed [NB_FR-1:0] fr_d, fr_q;
    qmode_e                  mode_q;
    logic                    v1_q, v2_q, ovf_q, stky_q, stky_d, q_ovf;
    logic [NB_OUT-1:0]       q_data, data_q;

    // single stall signal: both stages move together whenever the output slot frees up
    assign adv    = ~v2_q | bus.i_ready;
    assign cons   = v2_q & bus.i_ready;
    assign fr_d   = (NB_FR'($signed(bus.i_A)) <<< SH_A) + (NB_FR'($signed(bus.i_B)) <<< SH_B);
    assign stky_d = ~bus.i_clr & (stky_q | (cons & ovf_q));

    fxp_quant #(
        .NB_FR   (NB_FR),
        .NBF_FR  (NBF_FR),
        .NB_OUT  (NB_OUT),
        .NBF_OUT (NBF_OUT)
    ) u_quant (
        .fr_i   (fr_q),
        .mode_i (mode_q),
        .data_o (q_data),
        .ovf_o  (q_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            fr_q   <= '0;
            mode_q <= QM_TRUNC_WRAP;
            data_q <= '0;
            ovf_q  <= 1'b0;
            stky_q <= 1'b0;
        end else begin
            stky_q <= stky_d;
            if (adv) begin
                v1_q   <= bus.i_valid;
                fr_q   <= fr_d;
                mode_q <= qmode_e'(bus.i_mode);
                v2_q   <= v1_q;
                data_q <= q_data;
                ovf_q  <= q_ovf;
            end
        end
    end

`ifdef SUMFP_SAT_CNT_EN
    logic              sat_q;
    logic [NB_CNT-1:0] cnt_q, cnt_d;

    assign cnt_d = bus.i_clr ? '0 :
                   (cons & sat_q & ~(&cnt_q)) ? cnt_q + NB_CNT'(1) : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (adv) sat_q <= q_ovf & (mode_q != QM_TRUNC_WRAP);
        end
    end

    assign bus.o_sat_cnt = cnt_q;
`else
    assign bus.o_sat_cnt = '0;
`endif

    assign bus.o_ready    = adv;
    assign bus.o_valid    = v2_q;
    assign bus.o_data     = data_q;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_ovf_stky = stky_q;
endmodule

// File: tb/tb_sumfp_quant_pipe.sv
// tb_sumfp_quant_pipe: directed + random traffic against an arithmetic reference and scoreboard
module tb_sumfp_quant_pipe;
    import sumfp_pkg::*;

    typedef struct {
        logic [NB_OUT-1:0] d;
        logic              o;
        int                m;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    logic m_stky = 1'b0;
    exp_t q[$];

    logic [15:0] da  [7] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [11:0] db  [7] = '{12'h3FF, 12'h3FF, 12'h800, 12'h001, 12'h001, 12'h003, 12'h003};
    logic [1:0]  dm  [7] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [10:0] dd  [7] = '{11'h3FF, 11'h1FF, 11'h400, 11'h001, 11'h000, 11'h002, 11'h002};
    logic        dov [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] va  [8];
    logic [11:0] vb  [8];
    logic [1:0]  vm  [8];

    sumfp_quant_pipe_if bus ();
    sumfp_quant_pipe dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // A is in units of 2^-14, B of 2^-11; output LSB is 2^-10
    function automatic exp_t model(input int a, input int b, input int m);
        exp_t e;
        int   s, f, rem;
        s   = a + b * 8;
        f   = s >>> 4;
        rem = s - f * 16;
        if (m == 2 && rem >= 8) f++;
        if (m == 3 && (rem > 8 || (rem == 8 && (f & 1) == 1))) f++;
        e.o = (f > 1023 || f < -1024);
        e.d = (m != 0 && e.o) ? ((f > 0) ? 11'h3FF : 11'h400) : 11'(f);
        e.m = m;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [15:0] a, input logic [11:0] b,
                       input logic [1:0] m, input logic r, input logic c);
        bus.i_valid = v;
        bus.i_A     = a;
        bus.i_B     = b;
        bus.i_mode  = m;
        bus.i_ready = r;
        bus.i_clr   = c;
    endtask

    task automatic idle(input logic r, input logic c);
        drv(1'b0, 16'h0000, 12'h000, 2'd0, r, c);
    endtask

    task automatic tick(output logic acc);
        exp_t e;
        @(negedge clk);
        check("ready_rule", 32'(bus.o_ready), 32'(!bus.o_valid || bus.i_ready));
        acc = bus.i_valid && bus.o_ready;
        if (bus.o_valid && bus.i_ready) begin
            if (q.size() == 0) check("spurious_valid", 32'(bus.o_valid), 0);
            else begin
                e = q.pop_front();
                check("sb_data", 32'(bus.o_data), 32'(e.d));
                check("sb_ovf", 32'(bus.o_ovf), 32'(e.o));
                if (e.o) begin
                    m_stky = 1'b1;
                    if (e.m != 0 && m_cnt < 65535) m_cnt++;
                end
            end
        end
        if (bus.i_clr) begin
            m_stky = 1'b0;
            m_cnt  = 0;
        end
        if (acc) q.push_back(model(int'($signed(bus.i_A)), int'($signed(bus.i_B)), int'(bus.i_mode)));
        @(posedge clk);
        #1;
        check("stky", 32'(bus.o_ovf_stky), 32'(m_stky));
`ifdef SUMFP_SAT_CNT_EN
        check("sat_cnt", 32'(bus.o_sat_cnt), m_cnt);
`else
        check("sat_cnt", 32'(bus.o_sat_cnt), 0);
`endif
    endtask

    initial begin
        logic acc;
        int   k;
        idle(1'b1, 1'b0);
        #12;
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_data", 32'(bus.o_data), 0);
        check("rst_ovf", 32'(bus.o_ovf), 0);
        check("rst_stky", 32'(bus.o_ovf_stky), 0);
        check("rst_cnt", 32'(bus.o_sat_cnt), 0);
        check("rst_ready", 32'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drv(1'b1, 16'h2000, 12'h200, 2'd0, 1'b1, 1'b0);
        tick(acc);
        check("lat_accept", 32'(acc), 1);
        check("lat_1", 32'(bus.o_valid), 0);
        idle(1'b1, 1'b0);
        tick(acc);
        check("lat_2", 32'(bus.o_valid), 1);
        check("sum_300", 32'(bus.o_data), 'h300);
        check("sum_300_ovf", 32'(bus.o_ovf), 0);
        tick(acc);

        for (int i = 0; i < 7; i++) begin
            drv(1'b1, da[i], db[i], dm[i], 1'b1, 1'b0);
            tick(acc);
            idle(1'b1, 1'b0);
            tick(acc);
            check($sformatf("dir%0d_data", i), 32'(bus.o_data), 32'(dd[i]));
            check($sformatf("dir%0d_ovf", i), 32'(bus.o_ovf), 32'(dov[i]));
            tick(acc);
        end
        check("dir_stky", 32'(bus.o_ovf_stky), 1);

        drv(1'b1, 16'h8000, 12'h800, 2'd1, 1'b1, 1'b0);
        tick(acc);
        idle(1'b1, 1'b0);
        tick(acc);
        check("clr_pre_ovf", 32'(bus.o_ovf), 1);
        idle(1'b1, 1'b1);
        tick(acc);
        check("clr_stky", 32'(bus.o_ovf_stky), 0);
        check("clr_cnt", 32'(bus.o_sat_cnt), 0);

        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 12'($urandom);
            vm[i] = 2'($urandom_range(0, 3));
        end
        k = 0;
        for (int c = 0; c < 40 && (k < 8 || q.size() > 0); c++) begin
            drv(k < 8, va[(k < 8) ? k : 0], vb[(k < 8) ? k : 0], vm[(k < 8) ? k : 0], !(c >= 3 && c < 6), 1'b0);
            tick(acc);
            if (acc) k++;
            if (c >= 3 && c < 6) check("stall_ready", 32'(bus.o_ready), 0);
        end
        check("stream_sent", k, 8);
        check("stream_drained", q.size(), 0);

        k = 0;
        for (int c = 0; c < 300 && (k < 40 || q.size() > 0); c++) begin
            drv(k < 40 && $urandom_range(0, 3) != 0, 16'($urandom), 12'($urandom),
                2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            tick(acc);
            if (acc) k++;
        end
        check("rand_sent", k, 40);
        check("rand_drained", q.size(), 0);

        drv(1'b1, 16'h7FFF, 12'h3FF, 2'd1, 1'b1, 1'b0);
        tick(acc);
        tick(acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 0);
        check("mid_rst_data", 32'(bus.o_data), 0);
        check("mid_rst_ovf", 32'(bus.o_ovf), 0);
        check("mid_rst_stky", 32'(bus.o_ovf_stky), 0);
        check("mid_rst_cnt", 32'(bus.o_sat_cnt), 0);
        q.delete();
        m_stky = 1'b0;
        m_cnt  = 0;
        idle(1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_ready", 32'(bus.o_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("post_rst_valid", 32'(bus.o_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
